multireceive: RTL and testbench

//  Receive-side stage for the 3-lane keylock link. Consumes the out0/out1/out2/controlOut

---
 rtl/multireceive.sv | 159 +++++++++++++++
 tb/tb_multireceive.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/multireceive.sv
// multireceive: receive stage of the 3-lane keylock link.
// Rebuilds a WIDTH-bit word from strobed 3-bit symbols (LSB symbol first), compares
// each complete frame against KEY, and latches a sticky lockout after FAIL_LIMIT
// consecutive mismatching frames.
module multireceive #(
  parameter int              WIDTH      = 32,
  parameter logic [WIDTH-1:0] KEY        = 32'd555116,
  parameter int              FAIL_LIMIT = 3
) (
  input  logic             hwclk,
  input  logic             reset,
  input  logic             enabled,
  input  logic             in0,
  input  logic             in1,
  input  logic             in2,
  input  logic             controlIn,
  output logic [WIDTH-1:0] num,
  output logic             valid,
  output logic             match,
  output logic             err,
  output logic             busy,
  output logic             locked
);

  localparam int SYMBOLS = (WIDTH + 2) / 3;
  localparam int CW      = $clog2(SYMBOLS + 1);
  localparam int FW      = 4;

  typedef enum logic [1:0] {IDLE, RECV, DONE} state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] word_q, word_d;
  logic [WIDTH-1:0] num_q, num_d;
  logic             valid_q, valid_d;
  logic             match_q, match_d;
  logic             err_q, err_d;
  logic             locked_q, locked_d;
  logic [FW-1:0]    fail_q, fail_d;
  logic             ovr_q, ovr_d;

  logic [2:0]       lanes;
  logic [WIDTH-1:0] cap_word;
  logic [CW-1:0]    cap_idx;
  logic             cap_last;
  logic             complete;

  assign lanes = {in2, in1, in0};

  // Merge the current symbol into the partial word; a frame always restarts from zero in IDLE.
  always_comb begin
    // NOTE: every signal written here gets a default first so no latch can be inferred.
    cap_idx  = (state_q == IDLE) ? '0 : cnt_q;
    cap_word = (state_q == IDLE) ? '0 : word_q;
    for (int i = 0; i < WIDTH; i++) begin
      if ((i / 3) == int'(cap_idx)) cap_word[i] = lanes[i % 3];
    end
    cap_last = (cap_idx == CW'(SYMBOLS - 1));
  end

  // Next-state, framing, error pulses and key check.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    word_d   = word_q;
    num_d    = num_q;
    valid_d  = 1'b0;
    match_d  = match_q;
    err_d    = 1'b0;
    locked_d = locked_q;
    fail_d   = fail_q;
    ovr_d    = ovr_q;
    complete = 1'b0;

    if (!enabled) begin
      // Disabling silently abandons any partial frame.
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE, RECV: begin
          if (controlIn) begin
            word_d = cap_word;
            cnt_d  = cap_idx + CW'(1);
            if (cap_last) begin
              state_d  = DONE;
              ovr_d    = 1'b0;
              complete = 1'b1;
            end else begin
              state_d = RECV;
            end
          end else if (state_q == RECV) begin
            // Strobe dropped before the last symbol: short frame.
            err_d   = 1'b1;
            state_d = IDLE;
          end
        end
        DONE: begin
          if (!controlIn) begin
            state_d = IDLE;
          end else if (!ovr_q) begin
            // Overrun is reported once per frame; extra symbols are dropped.
            err_d = 1'b1;
            ovr_d = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    if (complete) begin
      num_d   = cap_word;
      valid_d = 1'b1;
      if (cap_word == KEY) begin
        match_d = !locked_q;
        if (!locked_q) fail_d = '0;
      end else begin
        match_d = 1'b0;
        if (fail_q < FW'(FAIL_LIMIT)) fail_d = fail_q + FW'(1);
        if (fail_d == FW'(FAIL_LIMIT)) locked_d = 1'b1;
      end
    end
  end

  // State and output registers; reset clears everything immediately.
  always_ff @(posedge hwclk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      word_q   <= '0;
      num_q    <= '0;
      valid_q  <= 1'b0;
      match_q  <= 1'b0;
      err_q    <= 1'b0;
      locked_q <= 1'b0;
      fail_q   <= '0;
      ovr_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      word_q   <= word_d;
      num_q    <= num_d;
      valid_q  <= valid_d;
      match_q  <= match_d;
      err_q    <= err_d;
      locked_q <= locked_d;
      fail_q   <= fail_d;
      ovr_q    <= ovr_d;
    end
  end

  assign num    = num_q;
  assign valid  = valid_q;
  assign match  = match_q;
  assign err    = err_q;
  assign locked = locked_q;
  assign busy   = (state_q != IDLE);

endmodule

// File: tb/tb_multireceive.sv
// tb_multireceive: directed frame table, reset/abort sequences and random frames
// checked against a frame-level model of the keylock receiver.
module tb_multireceive;

  localparam logic [31:0] KEY   = 32'd555116;
  localparam int          LIMIT = 3;

  logic        hwclk = 1'b0;
  logic        reset, enabled, in0, in1, in2, controlIn;
  logic [31:0] num;
  logic        valid, match, err, busy, locked;

  multireceive dut (
    .hwclk(hwclk), .reset(reset), .enabled(enabled),
    .in0(in0), .in1(in1), .in2(in2), .controlIn(controlIn),
    .num(num), .valid(valid), .match(match), .err(err),
    .busy(busy), .locked(locked)
  );

  always #5 hwclk = ~hwclk;

  int n_checks = 0;
  int n_fail   = 0;

  // Observations collected during one frame (cycle numbers are 1-based edges).
  int v_first, v_cnt, e_first, e_cnt, both_cnt;
  bit busy_tr [0:31];

  // Frame-level reference model.
  logic [31:0] m_num;
  bit          m_match, m_locked;
  int          m_fail;

  typedef struct {
    logic [31:0] word;
    int          nsym;
    int          drop;
    int          vcyc;
    int          ecyc;
    logic [31:0] num;
    bit          match;
    bit          locked;
  } vec_t;

  vec_t tbl [13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive symbol c of word w (symbols past the word carry random lanes).
  task automatic drive_sym(input logic [31:0] w, input int c);
    logic [2:0] lb;
    for (int j = 0; j < 3; j++) begin
      int idx = 3 * c + j;
      if (c < 11 && idx < 32) lb[j] = w[idx];
      else lb[j] = 1'($urandom);
    end
    controlIn = 1'b1;
    {in2, in1, in0} = lb;
  endtask

  task automatic send(input logic [31:0] w, input int nsym, input int drop);
    v_first = 0; v_cnt = 0; e_first = 0; e_cnt = 0; both_cnt = 0;
    for (int k = 0; k < 32; k++) busy_tr[k] = 1'b0;
    for (int c = 0; c < nsym + 2; c++) begin
      @(negedge hwclk);
      enabled = (drop == 0 || c < drop);
      if (c < nsym) drive_sym(w, c);
      else begin
        controlIn = 1'b0;
        {in2, in1, in0} = 3'($urandom);
      end
      @(posedge hwclk);
      #1;
      if (valid) begin v_cnt++; if (v_first == 0) v_first = c + 1; end
      if (err)   begin e_cnt++; if (e_first == 0) e_first = c + 1; end
      if (valid && err) both_cnt++;
      if (c + 1 < 32) busy_tr[c + 1] = busy;
    end
    @(negedge hwclk);
    enabled = 1'b1;
  endtask

  task automatic check_frame(input string tag, input int vcyc, input int ecyc,
                             input logic [31:0] enum_v, input bit ematch, input bit elocked);
    check({tag, ".valid_cyc"}, v_first, vcyc);
    check({tag, ".valid_cnt"}, v_cnt, (vcyc != 0) ? 1 : 0);
    check({tag, ".err_cyc"}, e_first, ecyc);
    check({tag, ".err_cnt"}, e_cnt, (ecyc != 0) ? 1 : 0);
    check({tag, ".valid_err_overlap"}, both_cnt, 0);
    check({tag, ".num"}, num, enum_v);
    check({tag, ".match"}, 32'(match), 32'(ematch));
    check({tag, ".locked"}, 32'(locked), 32'(elocked));
    check({tag, ".busy_idle"}, 32'(busy), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ".num"}, num, 0);
    check({tag, ".valid"}, 32'(valid), 0);
    check({tag, ".match"}, 32'(match), 0);
    check({tag, ".err"}, 32'(err), 0);
    check({tag, ".busy"}, 32'(busy), 0);
    check({tag, ".locked"}, 32'(locked), 0);
  endtask

  task automatic do_reset();
    @(negedge hwclk);
    reset = 1'b1;
    controlIn = 1'b0;
    #1;
    check_reset_outputs("rand_reset");
    @(negedge hwclk);
    reset = 1'b0;
    m_num = '0; m_match = 1'b0; m_locked = 1'b0; m_fail = 0;
  endtask

  initial begin
    // word, nsym, drop, valid cyc, err cyc, num, match, locked
    tbl[0]  = '{KEY,          11, 0, 11,  0, KEY,          1'b1, 1'b0};
    tbl[1]  = '{32'h12345678, 11, 0, 11,  0, 32'h12345678, 1'b0, 1'b0};
    tbl[2]  = '{32'hDEADBEEF,  5, 0,  0,  6, 32'h12345678, 1'b0, 1'b0};
    tbl[3]  = '{32'h12345678, 11, 0, 11,  0, 32'h12345678, 1'b0, 1'b0};
    tbl[4]  = '{KEY,          13, 0, 11, 12, KEY,          1'b1, 1'b0};
    tbl[5]  = '{32'h12345678, 11, 0, 11,  0, 32'h12345678, 1'b0, 1'b0};
    tbl[6]  = '{KEY,          11, 4,  0,  0, 32'h12345678, 1'b0, 1'b0};
    tbl[7]  = '{32'h12345678, 11, 0, 11,  0, 32'h12345678, 1'b0, 1'b0};
    tbl[8]  = '{KEY,          11, 0, 11,  0, KEY,          1'b1, 1'b0};
    tbl[9]  = '{32'h12345678, 11, 0, 11,  0, 32'h12345678, 1'b0, 1'b0};
    tbl[10] = '{32'h12345678, 11, 0, 11,  0, 32'h12345678, 1'b0, 1'b0};
    tbl[11] = '{32'h12345678, 11, 0, 11,  0, 32'h12345678, 1'b0, 1'b1};
    tbl[12] = '{KEY,          11, 0, 11,  0, KEY,          1'b0, 1'b1};

    reset = 1'b1; enabled = 1'b1; controlIn = 1'b0;
    {in2, in1, in0} = 3'b000;
    #1;
    check_reset_outputs("reset_state");
    repeat (2) @(negedge hwclk);
    reset = 1'b0;

    // Directed frames.
    for (int i = 0; i < 13; i++) begin
      send(tbl[i].word, tbl[i].nsym, tbl[i].drop);
      check_frame($sformatf("vec%0d", i), tbl[i].vcyc, tbl[i].ecyc,
                  tbl[i].num, tbl[i].match, tbl[i].locked);
      if (i == 0) begin
        check("vec0.busy_last_sym", 32'(busy_tr[11]), 1);
        check("vec0.busy_after_fall", 32'(busy_tr[12]), 0);
      end
    end

    // Reset asserted while symbol 6 is on the lanes: outputs clear before any edge.
    for (int c = 0; c < 6; c++) begin
      @(negedge hwclk);
      drive_sym(KEY, c);
    end
    @(negedge hwclk);
    drive_sym(KEY, 6);
    check("pre_reset.busy", 32'(busy), 1);
    #2;
    reset = 1'b1;
    #1;
    check_reset_outputs("midframe_reset");
    @(negedge hwclk);
    controlIn = 1'b0;
    reset = 1'b0;
    send(KEY, 11, 0);
    check_frame("after_reset", 11, 0, KEY, 1'b1, 1'b0);

    // Random frames against the model.
    m_num = KEY; m_match = 1'b1; m_locked = 1'b0; m_fail = 0;
    for (int f = 0; f < 48; f++) begin
      logic [31:0] w;
      int nsym, drop, vc, ec;
      if (f % 12 == 11) do_reset();
      w    = ($urandom_range(0, 2) == 0) ? KEY : $urandom;
      nsym = $urandom_range(1, 13);
      drop = (nsym >= 11 && $urandom_range(0, 4) == 0) ? $urandom_range(1, 10) : 0;
      vc = 0; ec = 0;
      if (drop != 0) begin
        vc = 0;
      end else if (nsym < 11) begin
        ec = nsym + 1;
      end else begin
        vc = 11;
        if (nsym >= 12) ec = 12;
        m_num = w;
        if (w == KEY) begin
          m_match = !m_locked;
          if (!m_locked) m_fail = 0;
        end else begin
          m_match = 1'b0;
          if (m_fail < LIMIT) m_fail++;
          if (m_fail >= LIMIT) m_locked = 1'b1;
        end
      end
      send(w, nsym, drop);
      check_frame($sformatf("rand%0d", f), vc, ec, m_num, m_match, m_locked);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
